uart_top: RTL and testbench

Full-duplex UART peripheral for a PicoBlaze-class processor port bus. Holds a transmit engine and a receive engine that share a runtime-programmable bit time (k), data length, and parity setup. Decoded port strobes (WRITES/READS) load TX data and read RX data or status. An interrupt pulse (PED_OUT) fires when the transmitter or receiver becomes ready.

---
 rtl/uart_top.sv | 252 +++++++++++++++++++++++++
 tb/tb_uart_top.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_top.sv
// uart_top: full-duplex UART peripheral for a PicoBlaze-style port bus.
// The transmit and receive engines share a bit time (k, in clk cycles), a data
// length (EIGHT) and a parity setup (PEN, OHEL), all supplied at runtime.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous reset, active low
//   EIGHT     1 = 8 data bits, 0 = 7 data bits
//   PEN       1 = parity bit present
//   OHEL      parity select, 1 = odd, 0 = even
//   RX        serial input, idle high
//   k         bit time in clk cycles (k >= 4)
//   READS     one-hot read strobes: bit0 = RX data, bit1 = status
//   WRITES    one-hot write strobes: bit0 = TX data
//   OUT_PORT  write data from the processor
//   TX        serial output, idle high
//   IN_PORT   read data to the processor (combinational from READS)
//   PED_OUT   one-cycle interrupt pulse when TXRDY or RXRDY rises
module uart_top (
   input  logic        clk,
   input  logic        rst,
   input  logic        EIGHT,
   input  logic        PEN,
   input  logic        OHEL,
   input  logic        RX,
   input  logic [18:0] k,
   input  logic [15:0] READS,
   input  logic [15:0] WRITES,
   input  logic [7:0]  OUT_PORT,
   output logic        TX,
   output logic [7:0]  IN_PORT,
   output logic        PED_OUT
);

   // Strobe bits with no function in this peripheral.
   logic unused_strobes;
   assign unused_strobes = ^{READS[15:2], WRITES[15:1]};

   // ------------------------------------------------------------------
   // Transmitter
   // ------------------------------------------------------------------
   typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;

   tx_state_t   tx_state_reg, tx_state_next;
   logic [10:0] tx_shift_reg;
   logic [3:0]  tx_left_reg;
   logic [18:0] tx_cnt_reg;
   logic [10:0] tx_frame;
   logic [7:0]  tx_data;
   logic [3:0]  tx_nbits;
   logic        tx_par;
   logic        tx_bit_done;
   logic        txrdy;

   assign tx_data     = {EIGHT & OUT_PORT[7], OUT_PORT[6:0]};
   assign tx_par      = (^tx_data) ^ OHEL;
   assign tx_nbits    = 4'd9 + {3'b000, EIGHT} + {3'b000, PEN};
   // ">=" keeps a shrinking k from stranding the counter mid-bit.
   assign tx_bit_done = (tx_cnt_reg >= k - 19'd1);

   // Whole frame, LSB first: start, data, optional parity, stop, 1s padding.
   // Configuration is captured here at the write, so the frame in flight
   // cannot be disturbed by later changes to EIGHT/PEN/OHEL.
   genvar gi;
   generate
      for (gi = 0; gi < 11; gi++) begin : g_frame
         if (gi == 0) begin : g_start
            assign tx_frame[gi] = 1'b0;
         end else if (gi <= 7) begin : g_data
            assign tx_frame[gi] = OUT_PORT[gi-1];
         end else if (gi == 8) begin : g_b8
            assign tx_frame[gi] = EIGHT ? OUT_PORT[7] : (PEN ? tx_par : 1'b1);
         end else if (gi == 9) begin : g_b9
            assign tx_frame[gi] = (EIGHT && PEN) ? tx_par : 1'b1;
         end else begin : g_pad
            assign tx_frame[gi] = 1'b1;
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) tx_state_reg <= TX_IDLE;
      else      tx_state_reg <= tx_state_next;
   end

   always_comb begin
      tx_state_next = tx_state_reg;
      case (tx_state_reg)
         TX_IDLE:  if (WRITES[0]) tx_state_next = TX_SHIFT;
         TX_SHIFT: if (tx_bit_done && tx_left_reg == 4'd1) tx_state_next = TX_IDLE;
         default:  tx_state_next = TX_IDLE;
      endcase
   end

   always_comb begin
      txrdy = (tx_state_reg == TX_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_shift_reg <= '1;
         tx_left_reg  <= 4'd0;
         tx_cnt_reg   <= 19'd0;
      end else if (tx_state_reg == TX_IDLE) begin
         tx_cnt_reg <= 19'd0;
         if (WRITES[0]) begin
            tx_shift_reg <= tx_frame;
            tx_left_reg  <= tx_nbits;
         end
      end else if (tx_bit_done) begin
         tx_shift_reg <= {1'b1, tx_shift_reg[10:1]};
         tx_left_reg  <= tx_left_reg - 4'd1;
         tx_cnt_reg   <= 19'd0;
      end else begin
         tx_cnt_reg <= tx_cnt_reg + 19'd1;
      end
   end

   assign TX = tx_shift_reg[0];

   // ------------------------------------------------------------------
   // Receiver
   // ------------------------------------------------------------------
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   rx_state_t   rx_state_reg, rx_state_next;
   logic        rx_s1_reg, rx_s2_reg, rx_s3_reg;
   logic [18:0] rx_cnt_reg;
   logic [3:0]  rx_idx_reg;
   logic [8:0]  rx_bits_reg;
   logic        rx_eight_reg, rx_pen_reg, rx_ohel_reg;
   logic [7:0]  rx_data_reg;
   logic        rxrdy_reg, perr_reg, ferr_reg, ovf_reg;
   logic        txrdy_d_reg, rxrdy_d_reg;
   logic        rx_fall, rx_half_hit, rx_bit_done;
   logic [3:0]  rx_last;
   logic        rx_done;
   logic [7:0]  rx_data_new;
   logic        rx_par_bit, rx_perr_new;

   // rx_s3_reg is the previous synchronized value, used only for edge detect.
   assign rx_fall     = rx_s3_reg & ~rx_s2_reg;
   assign rx_half_hit = (rx_cnt_reg >= {1'b0, k[18:1]});
   assign rx_bit_done = (rx_cnt_reg >= k - 19'd1);
   // Index of the last bit collected before the stop bit (data + parity).
   assign rx_last     = 4'd6 + {3'b000, rx_eight_reg} + {3'b000, rx_pen_reg};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rx_state_reg <= RX_IDLE;
      else      rx_state_reg <= rx_state_next;
   end

   always_comb begin
      rx_state_next = rx_state_reg;
      case (rx_state_reg)
         RX_IDLE:  if (rx_fall) rx_state_next = RX_START;
         RX_START: if (rx_half_hit) rx_state_next = rx_s2_reg ? RX_IDLE : RX_DATA;
         RX_DATA:  if (rx_bit_done && rx_idx_reg == rx_last) rx_state_next = RX_STOP;
         RX_STOP:  if (rx_bit_done) rx_state_next = RX_IDLE;
         default:  rx_state_next = RX_IDLE;
      endcase
   end

   always_comb begin
      rx_done     = (rx_state_reg == RX_STOP) && rx_bit_done;
      rx_data_new = {rx_eight_reg & rx_bits_reg[7], rx_bits_reg[6:0]};
      rx_par_bit  = rx_eight_reg ? rx_bits_reg[8] : rx_bits_reg[7];
      rx_perr_new = rx_pen_reg && (((^rx_data_new) ^ rx_par_bit) != rx_ohel_reg);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_s1_reg    <= 1'b1;
         rx_s2_reg    <= 1'b1;
         rx_s3_reg    <= 1'b1;
         rx_cnt_reg   <= 19'd0;
         rx_idx_reg   <= 4'd0;
         rx_bits_reg  <= 9'd0;
         rx_eight_reg <= 1'b1;
         rx_pen_reg   <= 1'b0;
         rx_ohel_reg  <= 1'b0;
      end else begin
         rx_s1_reg <= RX;
         rx_s2_reg <= rx_s1_reg;
         rx_s3_reg <= rx_s2_reg;
         case (rx_state_reg)
            RX_IDLE: begin
               rx_cnt_reg <= 19'd0;
               rx_idx_reg <= 4'd0;
               if (rx_fall) begin
                  rx_bits_reg  <= 9'd0;
                  rx_eight_reg <= EIGHT;
                  rx_pen_reg   <= PEN;
                  rx_ohel_reg  <= OHEL;
               end
            end
            RX_START: rx_cnt_reg <= rx_half_hit ? 19'd0 : rx_cnt_reg + 19'd1;
            RX_DATA: begin
               if (rx_bit_done) begin
                  rx_bits_reg[rx_idx_reg] <= rx_s2_reg;
                  rx_idx_reg <= rx_idx_reg + 4'd1;
                  rx_cnt_reg <= 19'd0;
               end else begin
                  rx_cnt_reg <= rx_cnt_reg + 19'd1;
               end
            end
            default: rx_cnt_reg <= rx_bit_done ? 19'd0 : rx_cnt_reg + 19'd1;
         endcase
      end
   end

   // Status flags: a completing frame beats a simultaneous data read.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_data_reg <= 8'd0;
         rxrdy_reg   <= 1'b0;
         perr_reg    <= 1'b0;
         ferr_reg    <= 1'b0;
         ovf_reg     <= 1'b0;
         txrdy_d_reg <= 1'b1;
         rxrdy_d_reg <= 1'b0;
      end else begin
         txrdy_d_reg <= txrdy;
         rxrdy_d_reg <= rxrdy_reg;
         if (rx_done) begin
            rx_data_reg <= rx_data_new;
            rxrdy_reg   <= 1'b1;
            perr_reg    <= rx_perr_new | (perr_reg & ~READS[0]);
            ferr_reg    <= ~rx_s2_reg  | (ferr_reg & ~READS[0]);
            ovf_reg     <= rxrdy_reg   | (ovf_reg  & ~READS[0]);
         end else if (READS[0]) begin
            rxrdy_reg <= 1'b0;
            perr_reg  <= 1'b0;
            ferr_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Processor interface and interrupt
   // ------------------------------------------------------------------
   always_comb begin
      IN_PORT = 8'h00;
      if (READS[0])      IN_PORT = rx_data_reg;
      else if (READS[1]) IN_PORT = {3'b000, ovf_reg, ferr_reg, perr_reg, txrdy, rxrdy_reg};
   end

   // txrdy_d_reg resets to 1 so leaving reset does not look like a rising edge.
   assign PED_OUT = (txrdy & ~txrdy_d_reg) | (rxrdy_reg & ~rxrdy_d_reg);

endmodule

// File: tb/tb_uart_top.sv
module tb_uart_top;

   logic        clk = 1'b0;
   logic        rst;
   logic        EIGHT, PEN, OHEL, RX;
   logic [18:0] k;
   logic [15:0] READS, WRITES;
   logic [7:0]  OUT_PORT;
   logic        TX;
   logic [7:0]  IN_PORT;
   logic        PED_OUT;

   int checks = 0;
   int errors = 0;
   int ped_count = 0;

   // Reference receiver status, kept at the level of the port-visible flags.
   bit       m_rxrdy, m_perr, m_ferr, m_ovf;
   bit [7:0] m_data;

   uart_top dut (
      .clk(clk), .rst(rst), .EIGHT(EIGHT), .PEN(PEN), .OHEL(OHEL), .RX(RX),
      .k(k), .READS(READS), .WRITES(WRITES), .OUT_PORT(OUT_PORT),
      .TX(TX), .IN_PORT(IN_PORT), .PED_OUT(PED_OUT)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (rst === 1'b1 && PED_OUT === 1'b1) ped_count++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit par_bit(input bit [7:0] d, input bit odd);
      return bit'($countones(d) & 1) ^ odd;
   endfunction

   function automatic bit [7:0] exp_status();
      return {3'b000, m_ovf, m_ferr, m_perr, 1'b1, m_rxrdy};
   endfunction

   task automatic model_clear();
      m_rxrdy = 0; m_perr = 0; m_ferr = 0; m_ovf = 0;
   endtask

   // Transmit one frame and check TX / TXRDY / PED_OUT every clock.
   task automatic send_tx(input bit [7:0] d, input bit e8, input bit pe, input bit oh,
                          input int kk, input bit poke);
      bit [7:0] dm;
      bit       exp_bits[$];
      int       ped0;
      int       bad;
      dm = e8 ? d : (d & 8'h7F);
      exp_bits.push_back(1'b0);
      for (int i = 0; i < (e8 ? 8 : 7); i++) exp_bits.push_back(dm[i]);
      if (pe) exp_bits.push_back(par_bit(dm, oh));
      exp_bits.push_back(1'b1);
      EIGHT = e8; PEN = pe; OHEL = oh; k = 19'(kk);
      OUT_PORT = d; WRITES = 16'h0001; READS = 16'h0002;
      ped0 = ped_count;
      bad = 0;
      tick();
      WRITES = 16'h0000;
      // Scramble the configuration: the frame in flight must not change.
      EIGHT = ~e8; PEN = ~pe; OHEL = ~oh; OUT_PORT = 8'($urandom);
      for (int b = 0; b < exp_bits.size(); b++) begin
         for (int c = 0; c < kk; c++) begin
            checks++;
            if (TX !== exp_bits[b] || IN_PORT[1] !== 1'b0 || PED_OUT !== 1'b0) begin
               errors++;
               bad++;
               if (bad <= 4)
                  $display("FAIL tx_bit data=%02h bit=%0d clk=%0d TX=%b TXRDY=%b PED=%b required TX=%b TXRDY=0 PED=0",
                           d, b, c, TX, IN_PORT[1], PED_OUT, exp_bits[b]);
            end
            if (poke && b == 4 && c == 0) begin
               WRITES = 16'h0001;
               OUT_PORT = 8'hFF;
            end
            tick();
            WRITES = 16'h0000;
         end
      end
      checks++;
      if (TX !== 1'b1 || IN_PORT[1] !== 1'b1 || PED_OUT !== 1'b1) begin
         errors++;
         $display("FAIL tx_done data=%02h TX=%b TXRDY=%b PED=%b required 1 1 1", d, TX, IN_PORT[1], PED_OUT);
      end
      tick();
      checks++;
      if (PED_OUT !== 1'b0 || ped_count - ped0 !== 1) begin
         errors++;
         $display("FAIL tx_pulse data=%02h PED=%b pulses=%0d required PED=0 pulses=1", d, PED_OUT, ped_count - ped0);
      end
      $display("tx data=%02h eight=%0d pen=%0d odd=%0d k=%0d bits=%0d", d, e8, pe, oh, kk, exp_bits.size());
      READS = 16'h0000;
   endtask

   // Drive one serial frame onto RX and update the reference status.
   task automatic send_rx(input bit [7:0] d, input bit e8, input bit pe, input bit oh,
                          input int kk, input bit bad_par, input bit bad_stop);
      bit [7:0] dm;
      bit       fr[$];
      int       ped0;
      int       exp_pulses;
      dm = e8 ? d : (d & 8'h7F);
      fr.push_back(1'b0);
      for (int i = 0; i < (e8 ? 8 : 7); i++) fr.push_back(dm[i]);
      if (pe) fr.push_back(par_bit(dm, oh) ^ bad_par);
      fr.push_back(~bad_stop);
      EIGHT = e8; PEN = pe; OHEL = oh; k = 19'(kk); READS = 16'h0000;
      ped0 = ped_count;
      exp_pulses = m_rxrdy ? 0 : 1;
      foreach (fr[i]) begin
         RX = fr[i];
         repeat (kk) tick();
      end
      RX = 1'b1;
      repeat (2 * kk) tick();
      m_ovf  = m_ovf | m_rxrdy;
      m_rxrdy = 1;
      m_perr = m_perr | (pe & bad_par);
      m_ferr = m_ferr | bad_stop;
      m_data = dm;
      checks++;
      if (ped_count - ped0 !== exp_pulses) begin
         errors++;
         $display("FAIL rx_pulse data=%02h pulses=%0d required %0d", d, ped_count - ped0, exp_pulses);
      end
      $display("rx data=%02h eight=%0d pen=%0d odd=%0d k=%0d bad_par=%0d bad_stop=%0d", d, e8, pe, oh, kk, bad_par, bad_stop);
   endtask

   task automatic check_status(input string name);
      READS = 16'h0002;
      #1;
      checks++;
      if (IN_PORT !== exp_status()) begin
         errors++;
         $display("FAIL %s status=%02h required %02h", name, IN_PORT, exp_status());
      end
      READS = 16'h0000;
   endtask

   task automatic read_data(input string name);
      READS = 16'h0001;
      #1;
      checks++;
      if (IN_PORT !== m_data) begin
         errors++;
         $display("FAIL %s data=%02h required %02h", name, IN_PORT, m_data);
      end
      tick();
      READS = 16'h0000;
      model_clear();
   endtask

   task automatic test_reset();
      rst = 1'b0; RX = 1'b1; EIGHT = 1'b1; PEN = 1'b0; OHEL = 1'b0; k = 19'd16;
      READS = 16'h0000; WRITES = 16'h0000; OUT_PORT = 8'h00;
      model_clear();
      m_data = 8'h00;
      repeat (3) tick();
      checks++;
      if (TX !== 1'b1 || PED_OUT !== 1'b0 || IN_PORT !== 8'h00) begin
         errors++;
         $display("FAIL reset_out TX=%b PED=%b IN_PORT=%02h required 1 0 00", TX, PED_OUT, IN_PORT);
      end
      check_status("reset_status");
      rst = 1'b1;
      repeat (4) tick();
      checks++;
      if (ped_count !== 0 || TX !== 1'b1) begin
         errors++;
         $display("FAIL reset_release pulses=%0d TX=%b required 0 1", ped_count, TX);
      end
      check_status("post_reset_status");
      $display("reset done");
   endtask

   task automatic test_tx_8n1();
      send_tx(8'h55, 1'b1, 1'b0, 1'b0, 16, 1'b1);
   endtask

   task automatic test_tx_7e1();
      send_tx(8'h83, 1'b0, 1'b1, 1'b0, 16, 1'b0);
   endtask

   task automatic test_tx_random();
      for (int n = 0; n < 5; n++)
         send_tx(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 int'($urandom_range(4, 10)), 1'($urandom));
   endtask

   task automatic test_rx_8o1();
      send_rx(8'hA5, 1'b1, 1'b1, 1'b1, 16, 1'b0, 1'b0);
      check_status("rx_8o1_status");
      read_data("rx_8o1_data");
      check_status("rx_8o1_cleared");
   endtask

   task automatic test_rx_errors();
      send_rx(8'h3C, 1'b1, 1'b1, 1'b0, 16, 1'b1, 1'b0);
      check_status("rx_perr");
      read_data("rx_perr_data");
      send_rx(8'h5A, 1'b1, 1'b0, 1'b0, 16, 1'b0, 1'b1);
      check_status("rx_ferr");
      read_data("rx_ferr_data");
      send_rx(8'h11, 1'b1, 1'b0, 1'b0, 16, 1'b0, 1'b0);
      send_rx(8'hE7, 1'b1, 1'b0, 1'b0, 16, 1'b0, 1'b0);
      check_status("rx_ovf");
      read_data("rx_ovf_data");
      check_status("rx_ovf_cleared");
   endtask

   task automatic test_rx_random();
      bit e8, pe;
      for (int n = 0; n < 6; n++) begin
         e8 = 1'($urandom);
         pe = 1'($urandom);
         send_rx(8'($urandom), e8, pe, 1'($urandom), int'($urandom_range(8, 24)),
                 pe & ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
         check_status("rx_rand_status");
         read_data("rx_rand_data");
      end
   endtask

   task automatic test_false_start();
      int ped0;
      k = 19'd16; EIGHT = 1'b1; PEN = 1'b0;
      ped0 = ped_count;
      RX = 1'b0;
      repeat (5) tick();
      RX = 1'b1;
      repeat (48) tick();
      checks++;
      if (ped_count !== ped0) begin
         errors++;
         $display("FAIL false_start_pulse pulses=%0d required 0", ped_count - ped0);
      end
      check_status("false_start_status");
      $display("rx false start low=5 k=16");
      // A clean frame right after proves the receiver went back to idle.
      send_rx(8'h69, 1'b1, 1'b0, 1'b0, 16, 1'b0, 1'b0);
      check_status("after_false_status");
      read_data("after_false_data");
   endtask

   task automatic test_reset_mid_tx();
      int ped0;
      EIGHT = 1'b1; PEN = 1'b0; k = 19'd16;
      OUT_PORT = 8'h00; WRITES = 16'h0001;
      tick();
      WRITES = 16'h0000;
      repeat (30) tick();
      READS = 16'h0002;
      #1;
      checks++;
      if (TX !== 1'b0 || IN_PORT !== 8'h00) begin
         errors++;
         $display("FAIL mid_tx_busy TX=%b status=%02h required 0 00", TX, IN_PORT);
      end
      #1;
      rst = 1'b0;
      #1;
      checks++;
      if (TX !== 1'b1 || IN_PORT !== 8'h02 || PED_OUT !== 1'b0) begin
         errors++;
         $display("FAIL mid_tx_reset TX=%b status=%02h PED=%b required 1 02 0", TX, IN_PORT, PED_OUT);
      end
      model_clear();
      tick();
      rst = 1'b1;
      ped0 = ped_count;
      repeat (40) tick();
      checks++;
      if (ped_count !== ped0 || TX !== 1'b1 || IN_PORT !== 8'h02) begin
         errors++;
         $display("FAIL mid_tx_release pulses=%0d TX=%b status=%02h required 0 1 02", ped_count - ped0, TX, IN_PORT);
      end
      READS = 16'h0000;
      $display("reset during tx");
      send_tx(8'hC3, 1'b1, 1'b1, 1'b0, 8, 1'b0);
   endtask

   initial begin
      test_reset();
      test_tx_8n1();
      test_tx_7e1();
      test_tx_random();
      test_rx_8o1();
      test_rx_errors();
      test_rx_random();
      test_false_start();
      test_reset_mid_tx();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
